// File: rtl/bus_pkg.sv
// Shared definitions for the bus arbiter/mux: arbitration FSM states,
// default geometry and the symbolic source codes of the datapath bus.
package bus_pkg;

    // Arbitration FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        LOCKED = 2'd2
    } arb_state_t;

    // Default geometry
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_NUM_SRC = 23;

    // Source codes as they appear on sel_code / bus_src
    localparam int R0    = 0;
    localparam int R1    = 1;
    localparam int R2    = 2;
    localparam int R3    = 3;
    localparam int R4    = 4;
    localparam int R5    = 5;
    localparam int R6    = 6;
    localparam int R7    = 7;
    localparam int R8    = 8;
    localparam int R9    = 9;
    localparam int R10   = 10;
    localparam int R11   = 11;
    localparam int R12   = 12;
    localparam int R13   = 13;
    localparam int R14   = 14;
    localparam int R15   = 15;
    localparam int HI    = 16;
    localparam int LO    = 17;
    localparam int ZHIGH = 18;
    localparam int ZLOW  = 19;
    localparam int PC    = 20;
    localparam int MDR   = 21;
    localparam int PORT  = 22;

endpackage

// File: rtl/bus_arbiter_mux_rr_pick.sv
// rr_pick: combinational round-robin search. Returns the first requesting
// source found walking upward from last_owner+1, wrapping at NUM_SRC-1, so
// last_owner itself is checked last (lowest priority).
module rr_pick #(
    parameter int NUM_SRC = 23,
    parameter int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   last_owner,
    output logic [SEL_W-1:0]   idx,
    output logic               found
);

    int               pos;
    logic [SEL_W-1:0] cand;

    // Priority walk: the first hit wins, later hits are ignored
    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        cand  = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            pos = int'(last_owner) + i;
            if (pos >= NUM_SRC) pos = pos - NUM_SRC;
            cand = SEL_W'(pos);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_mux.sv
// bus_arbiter_mux: registered source multiplexer for a shared datapath bus.
// arb_en=0 selects a source directly from sel_code; arb_en=1 runs a
// round-robin arbiter over src_req with an optional lock that keeps the
// current owner granted while it continues to request.
// Optional feature: define BUS_ARBITER_MUX_PARITY_EN to add bus_par, the
// registered even parity of bus_out.
module bus_arbiter_mux
    import bus_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_SRC = DEF_NUM_SRC,
    localparam int SEL_W  = $clog2(NUM_SRC)
) (
    input  logic                      clock,
    input  logic                      clear_n,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic                      arb_en,
    input  logic [SEL_W-1:0]          sel_code,
    input  logic                      sel_valid,
    input  logic [NUM_SRC-1:0]        src_req,
    input  logic                      lock,
    output logic [DATA_W-1:0]         bus_out,
    output logic                      bus_valid,
    output logic [SEL_W-1:0]          bus_src,
    output logic [NUM_SRC-1:0]        src_grant,
    output logic                      sel_err
`ifdef BUS_ARBITER_MUX_PARITY_EN
    ,
    output logic                      bus_par
`endif
);

    // Source words viewed as an indexable array
    logic [NUM_SRC-1:0][DATA_W-1:0] words;
    assign words = src_data;

    arb_state_t       state, state_d;
    logic [SEL_W-1:0] last_owner, last_d;

    logic [DATA_W-1:0]  out_d;
    logic               valid_d;
    logic [SEL_W-1:0]   src_d;
    logic [NUM_SRC-1:0] grant_d;
    logic               err_d;

    logic             code_ok;
    logic             owner_held;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;

    assign code_ok = (int'(sel_code) < NUM_SRC);

    // Owner keeps the bus only once it has been granted and still asks for it
    assign owner_held = ((state == GRANT) || (state == LOCKED)) &&
                        lock && src_req[last_owner];

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_rr_pick (
        .req        (src_req),
        .last_owner (last_owner),
        .idx        (pick_idx),
        .found      (pick_found)
    );

    // FSM state and round-robin pointer
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state      <= IDLE;
            last_owner <= SEL_W'(NUM_SRC - 1);
        end else begin
            state      <= state_d;
            last_owner <= last_d;
        end
    end

    // Next state and next output values for both modes
    always_comb begin
        state_d = state;
        last_d  = last_owner;
        out_d   = bus_out;
        valid_d = 1'b0;
        src_d   = bus_src;
        grant_d = '0;
        err_d   = 1'b0;

        if (!arb_en) begin
            // Direct mode: arbiter parked, pointer untouched
            state_d = IDLE;
            if (sel_valid) begin
                if (code_ok) begin
                    out_d             = words[sel_code];
                    src_d             = sel_code;
                    valid_d           = 1'b1;
                    grant_d[sel_code] = 1'b1;
                end else begin
                    out_d = words[0];
                    src_d = '0;
                    err_d = 1'b1;
                end
            end
        end else if (owner_held) begin
            state_d             = LOCKED;
            out_d               = words[last_owner];
            src_d               = last_owner;
            valid_d             = 1'b1;
            grant_d[last_owner] = 1'b1;
        end else if (pick_found) begin
            state_d           = GRANT;
            last_d            = pick_idx;
            out_d             = words[pick_idx];
            src_d             = pick_idx;
            valid_d           = 1'b1;
            grant_d[pick_idx] = 1'b1;
        end else begin
            state_d = IDLE;
        end
    end

    // Output registers: one clock from sampling edge to bus
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            bus_out   <= '0;
            bus_valid <= 1'b0;
            bus_src   <= '0;
            src_grant <= '0;
            sel_err   <= 1'b0;
        end else begin
            bus_out   <= out_d;
            bus_valid <= valid_d;
            bus_src   <= src_d;
            src_grant <= grant_d;
            sel_err   <= err_d;
        end
    end

`ifdef BUS_ARBITER_MUX_PARITY_EN
    // Even parity tracks bus_out on the same edge
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) bus_par <= 1'b0;
        else          bus_par <= ^out_d;
    end
`endif

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed table-driven bench for bus_arbiter_mux (default 23 x 32 build).
module tb_bus_arbiter_mux;

    localparam int DATA_W  = 32;
    localparam int NUM_SRC = 23;
    localparam int SEL_W   = 5;

    logic                      clock = 1'b0;
    logic                      clear_n = 1'b0;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic                      arb_en = 1'b0;
    logic [SEL_W-1:0]          sel_code = '0;
    logic                      sel_valid = 1'b0;
    logic [NUM_SRC-1:0]        src_req = '0;
    logic                      lock = 1'b0;
    logic [DATA_W-1:0]         bus_out;
    logic                      bus_valid;
    logic [SEL_W-1:0]          bus_src;
    logic [NUM_SRC-1:0]        src_grant;
    logic                      sel_err;
`ifdef BUS_ARBITER_MUX_PARITY_EN
    logic                      bus_par;
`endif

    bus_arbiter_mux #(.DATA_W(DATA_W), .NUM_SRC(NUM_SRC)) dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .src_data  (src_data),
        .arb_en    (arb_en),
        .sel_code  (sel_code),
        .sel_valid (sel_valid),
        .src_req   (src_req),
        .lock      (lock),
        .bus_out   (bus_out),
        .bus_valid (bus_valid),
        .bus_src   (bus_src),
        .src_grant (src_grant),
        .sel_err   (sel_err)
`ifdef BUS_ARBITER_MUX_PARITY_EN
        ,
        .bus_par   (bus_par)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic               arb;
        logic               sv;
        logic [SEL_W-1:0]   code;
        logic [NUM_SRC-1:0] req;
        logic               lk;
        logic [DATA_W-1:0]  e_out;
        logic               e_valid;
        logic [SEL_W-1:0]   e_src;
        logic [NUM_SRC-1:0] e_grant;
        logic               e_err;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Source k carries A5_kk_kk_kk except PC, which carries 0x1234
    function automatic logic [DATA_W-1:0] data_of(int k);
        if (k == 20) return 32'h0000_1234;
        return 32'hA500_0000 + DATA_W'(k) * 32'h0001_0101;
    endfunction

    function automatic logic [NUM_SRC-1:0] oh(int k);
        logic [NUM_SRC-1:0] r;
        r = '0;
        r[k] = 1'b1;
        return r;
    endfunction

    task automatic chk(string name, int idx, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [vec %0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(logic arb, logic sv, int code, logic [NUM_SRC-1:0] req, logic lk,
                       logic [DATA_W-1:0] eo, logic ev, int es, logic [NUM_SRC-1:0] eg, logic ee);
        vec_t v;
        v.arb = arb; v.sv = sv; v.code = SEL_W'(code); v.req = req; v.lk = lk;
        v.e_out = eo; v.e_valid = ev; v.e_src = SEL_W'(es); v.e_grant = eg; v.e_err = ee;
        vecs.push_back(v);
    endtask

    task automatic check_outputs(int idx, logic [DATA_W-1:0] eo, logic ev, logic [SEL_W-1:0] es,
                                 logic [NUM_SRC-1:0] eg, logic ee);
        chk("bus_out",   idx, 64'(bus_out),   64'(eo));
        chk("bus_valid", idx, 64'(bus_valid), 64'(ev));
        chk("bus_src",   idx, 64'(bus_src),   64'(es));
        chk("src_grant", idx, 64'(src_grant), 64'(eg));
        chk("sel_err",   idx, 64'(sel_err),   64'(ee));
`ifdef BUS_ARBITER_MUX_PARITY_EN
        chk("bus_par",   idx, 64'(bus_par),   64'(^eo));
`endif
    endtask

    logic [NUM_SRC-1:0] r56, r322, r101, r67;

    initial begin
        for (int k = 0; k < NUM_SRC; k++) src_data[k*DATA_W +: DATA_W] = data_of(k);
        r101 = 23'b101;
        r56  = oh(5) | oh(6);
        r322 = oh(3) | oh(22);
        r67  = oh(6) | oh(7);

        //   arb sv code req      lk  e_out               ev es  e_grant  ee
        add(0, 1, 20, '0,   0, 32'h0000_1234,     1, 20, oh(20), 0); // 0 direct PC
        add(0, 0, 0,  '0,   0, 32'h0000_1234,     0, 20, '0,     0); // 1 hold
        add(0, 1, 31, '0,   0, 32'hA500_0000,     0, 0,  '0,     1); // 2 illegal
        add(0, 0, 0,  '0,   0, 32'hA500_0000,     0, 0,  '0,     0); // 3 err drops
        add(0, 1, 22, '0,   0, 32'hA516_1616,     1, 22, oh(22), 0); // 4 top legal
        add(0, 1, 23, '0,   0, 32'hA500_0000,     0, 0,  '0,     1); // 5 first illegal
        add(0, 1, 0,  '0,   0, 32'hA500_0000,     1, 0,  oh(0),  0); // 6 code 0
        add(1, 0, 0,  r101, 0, 32'hA500_0000,     1, 0,  oh(0),  0); // 7 rr 0
        add(1, 0, 0,  r101, 0, 32'hA502_0202,     1, 2,  oh(2),  0); // 8 rr 2
        add(1, 0, 0,  r101, 0, 32'hA500_0000,     1, 0,  oh(0),  0); // 9 rr 0
        add(1, 0, 0,  r101, 0, 32'hA502_0202,     1, 2,  oh(2),  0); // 10 rr 2
        add(1, 0, 0,  '0,   0, 32'hA502_0202,     0, 2,  '0,     0); // 11 idle hold
        add(1, 0, 0,  oh(22), 0, 32'hA516_1616,   1, 22, oh(22), 0); // 12 own 22
        add(1, 0, 0,  r322, 0, 32'hA503_0303,     1, 3,  oh(3),  0); // 13 wrap -> 3
        add(1, 0, 0,  r322, 0, 32'hA516_1616,     1, 22, oh(22), 0); // 14 -> 22
        add(1, 0, 0,  r56,  1, 32'hA505_0505,     1, 5,  oh(5),  0); // 15 grant 5
        add(1, 0, 0,  r56,  1, 32'hA505_0505,     1, 5,  oh(5),  0); // 16 locked
        add(1, 0, 0,  r56,  1, 32'hA505_0505,     1, 5,  oh(5),  0); // 17 locked
        add(1, 0, 0,  r56,  0, 32'hA506_0606,     1, 6,  oh(6),  0); // 18 unlock -> 6
        add(1, 0, 0,  r56,  1, 32'hA506_0606,     1, 6,  oh(6),  0); // 19 lock 6
        add(0, 0, 0,  r56,  1, 32'hA506_0606,     0, 6,  '0,     0); // 20 mode drop
        add(1, 0, 0,  r56,  1, 32'hA505_0505,     1, 5,  oh(5),  0); // 21 lock abandoned
        add(1, 0, 0,  r56,  1, 32'hA505_0505,     1, 5,  oh(5),  0); // 22 locked 5
        add(1, 0, 0,  r67,  1, 32'hA506_0606,     1, 6,  oh(6),  0); // 23 owner drops
        add(1, 0, 0,  r56,  1, 32'hA506_0606,     1, 6,  oh(6),  0); // 24 lock 6

        // Reset state
        #1;
        check_outputs(-1, '0, 1'b0, '0, '0, 1'b0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        clear_n = 1'b1;

        foreach (vecs[i]) begin
            arb_en = vecs[i].arb; sel_valid = vecs[i].sv; sel_code = vecs[i].code;
            src_req = vecs[i].req; lock = vecs[i].lk;
            @(posedge clock); #1;
            check_outputs(i, vecs[i].e_out, vecs[i].e_valid, vecs[i].e_src,
                          vecs[i].e_grant, vecs[i].e_err);
        end

        // Reset in the middle of a lock: outputs clear without a clock edge
        #2;
        clear_n = 1'b0;
        #1;
        check_outputs(100, '0, 1'b0, '0, '0, 1'b0);
        @(negedge clock);
        clear_n = 1'b1;
        src_req = '1;
        lock    = 1'b0;
        arb_en  = 1'b1;
        @(posedge clock); #1;
        check_outputs(101, 32'hA500_0000, 1'b1, '0, oh(0), 1'b0);
        @(posedge clock); #1;
        check_outputs(102, 32'hA501_0101, 1'b1, 5'd1, oh(1), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_mux.md
BUS_ARBITER_MUX -- requirements
Module: bus_arbiter_mux

Interface
REQ-001 SHALL have parameter DATA_W, default 32, source word width in bits.
REQ-002 SHALL have parameter NUM_SRC, default 23, number of bus sources (2..64).
REQ-003 SHALL have derived localparam SEL_W = clog2(NUM_SRC), source code width.
REQ-004 SHALL have port clock  in  1  rising-edge clock; the block has one clock.
REQ-005 SHALL have port clear_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port src_data  in  NUM_SRC*DATA_W  packed source words; source k occupies bits [k*DATA_W +: DATA_W].
REQ-007 SHALL have port arb_en  in  1  mode: 0 = direct select, 1 = round-robin arbitration.
REQ-008 SHALL have port sel_code  in  SEL_W  direct-mode source code.
REQ-009 SHALL have port sel_valid  in  1  direct-mode select strobe.
REQ-010 SHALL have port src_req  in  NUM_SRC  arbitration requests, one bit per source.
REQ-011 SHALL have port lock  in  1  holds the current grant while the owner keeps its request asserted.
REQ-012 SHALL have port bus_out  out  DATA_W  registered bus word.
REQ-013 SHALL have port bus_valid  out  1  bus_out carries a transfer this cycle.
REQ-014 SHALL have port bus_src  out  SEL_W  code of the source driving bus_out.
REQ-015 SHALL have port src_grant  out  NUM_SRC  one-hot grant, registered.
REQ-016 SHALL have port sel_err  out  1  one-cycle pulse on an illegal direct code.

Function
REQ-017 SHALL register all outputs; transfer latency SHALL be exactly 1 clock from the sampling edge.
REQ-018 Direct mode: sel_valid=1 with sel_code<NUM_SRC SHALL load bus_out=src_data[sel_code], bus_src=sel_code, bus_valid=1, src_grant=one-hot(sel_code).
REQ-019 Direct mode: sel_valid=1 with sel_code>=NUM_SRC SHALL load source 0 data, set bus_src=0 and bus_valid=0, and pulse sel_err for 1 cycle.
REQ-020 Direct mode: sel_valid=0 SHALL hold bus_out and bus_src, and clear bus_valid and src_grant.
REQ-021 Arbitration SHALL use the FSM states IDLE, GRANT and LOCKED; direct mode SHALL force the FSM to IDLE and ignore src_req.
REQ-022 IDLE/GRANT: the FSM SHALL grant the first requesting source searching upward from (last_owner+1) mod NUM_SRC, wrapping past NUM_SRC-1 to 0.
REQ-023 last_owner SHALL reset to NUM_SRC-1, so source 0 has first priority after reset.
REQ-024 With no request, the FSM SHALL go to IDLE, clear bus_valid and src_grant, and hold bus_out.
REQ-025 GRANT->LOCKED SHALL occur when lock=1 and the owner's request=1; in LOCKED the owner SHALL be regranted every cycle regardless of other requests.
REQ-026 LOCKED->round-robin SHALL occur on the same edge on which lock=0 or the owner's request drops; the owner SHALL then be lowest priority.
REQ-027 A mode change (arb_en toggle) SHALL take effect on the next edge; a locked grant SHALL be abandoned and last_owner kept.
REQ-028 A grant SHALL be one-hot or zero at all times; bus_src SHALL equal the index of the granted bit.

Reset
REQ-029 On clear_n=0, asynchronously: bus_out=0, bus_valid=0, bus_src=0, src_grant=0, sel_err=0, state=IDLE, last_owner=NUM_SRC-1.
REQ-030 Reset asserted mid-transfer or mid-lock SHALL discard the transfer; the first grant after release SHALL follow REQ-023.

Configuration
REQ-031 Macro BUS_ARBITER_MUX_PARITY_EN defined: the block SHALL add output bus_par (1 bit), registered even parity of bus_out, reset 0 and updated on the same edge as bus_out.
REQ-032 Macro BUS_ARBITER_MUX_PARITY_EN undefined: bus_par SHALL be absent and there SHALL be no parity logic.

Structure
REQ-033 Package bus_pkg SHALL hold the FSM state enum, the default DATA_W/NUM_SRC constants, and the source-code constants (R0..R15=0..15, HI=16, LO=17, ZHIGH=18, ZLOW=19, PC=20, MDR=21, PORT=22).
REQ-034 The round-robin priority search SHALL be a combinational sub-module rr_pick (inputs req and last_owner; outputs idx and found).

Verification
REQ-035 Direct: sel_valid=1, sel_code=20 (PC), src_data[PC]=0x0000_1234 -> next cycle bus_out=0x0000_1234, bus_src=20, bus_valid=1, src_grant=1<<20.
REQ-036 Direct illegal: sel_code=31 with NUM_SRC=23 -> sel_err high for 1 cycle, bus_valid=0, bus_out=src_data[0].
REQ-037 Round-robin: src_req=0b101 held for 4 cycles after reset -> grants 0,2,0,2.
REQ-038 Wrap: last_owner=22, src_req bits {3,22} set -> grant 3, then 22.
REQ-039 Lock: source 5 granted with lock=1 and src_req={5,6} for 3 cycles -> grant 5 three times; then lock=0 -> grant 6.
REQ-040 Reset mid-lock: clear_n pulsed low during LOCKED -> outputs 0 immediately; after release with src_req=all ones -> first grant is 0.
